riscv_debug_ring_link_buffer: RTL and testbench
===============================================

Name: riscv_debug_ring_link_buffer

Overview:
Per-channel elastic buffer placed on the debug ring between two riscv_debug_misd_expand segments. It connects one segment's ext_out_* to the next segment's ext_in_*. It breaks the combinational ready path between segments and absorbs bursts. It supports cut-through and store-and-forward (packet-complete) release, with one independent FIFO per ring channel.

Parameters:
XLEN, 64, flit data width; matches ring flit width
CHANNELS, 2, number of ring channels (independent FIFOs)
DEPTH, 8, flits per channel FIFO; power of two, >= 2
STORE_FWD, 0, 0 = cut-through, 1 = hold output until a complete packet (last flit) is buffered

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
ring_in_data  input  [CHANNELS-1:0][XLEN-1:0]  flit from upstream segment ext_out_data
ring_in_last  input  [CHANNELS-1:0]  last flit of packet
ring_in_valid  input  [CHANNELS-1:0]  upstream flit valid
ring_in_ready  output  [CHANNELS-1:0]  buffer can accept flit
ring_out_data  output  [CHANNELS-1:0][XLEN-1:0]  flit to downstream segment ext_in_data
ring_out_last  output  [CHANNELS-1:0]  last flag of head flit
ring_out_valid  output  [CHANNELS-1:0]  head flit valid
ring_out_ready  input  [CHANNELS-1:0]  downstream accepts
fill  output  [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]  flits currently stored
pkt_cnt  output  [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]  complete packets currently stored

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-low.
- Reset (rst low):
  - Per channel: wr_ptr, rd_ptr, fill and pkt_cnt are 0.
  - ring_out_valid = 0.
  - ring_in_ready forced 0 while rst is low.
  - ring_out_data/ring_out_last are don't-care but stable.
  - Storage array is not reset.
- Channel independence: all state is per channel; channels never interact.
- Push: on the clock edge where ring_in_valid & ring_in_ready:
  - Write {last, data} at wr_ptr.
  - wr_ptr += 1, wrapping modulo DEPTH.
- Pop: on the clock edge where ring_out_valid & ring_out_ready:
  - rd_ptr += 1, wrapping modulo DEPTH.
- Ready: ring_in_ready = (fill < DEPTH). It is registered state only, with no combinational path from ring_out_ready.
- Full behaviour: when full, no push occurs even if a pop happens in the same cycle. No full-bypass.
- Head flit: ring_out_data/ring_out_last are driven from mem[rd_ptr].
- Valid, cut-through (STORE_FWD=0): ring_out_valid = (fill != 0).
- Valid, store-and-forward (STORE_FWD=1): ring_out_valid = (fill != 0) & ((pkt_cnt != 0) | (fill == DEPTH) | fwd_open).
  - fwd_open is a per-channel flag. It is set when the FIFO is full with pkt_cnt == 0 (oversize-packet escape, prevents deadlock).
  - It clears when a flit with last=1 is popped.
  - While fwd_open is set, the channel behaves as cut-through.
- Latency: minimum 1 cycle from an accepted input flit to ring_out_valid (no empty bypass). In STORE_FWD mode, the first flit is released 1 cycle after the last flit is accepted.
- Counters:
  - fill: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - pkt_cnt: +1 on a push with last=1, -1 on a pop with last=1, unchanged when both occur in the same cycle.
  - Neither counter underflows or overflows under legal handshakes.
- Handshake rules:
  - Upstream must hold data/last stable while valid & !ready. Buffer output obeys the same rule.
  - Once asserted, ring_out_valid stays high until popped.
  - The head flit does not change without a pop.
- Full throughput: one flit per cycle per channel when 0 < fill < DEPTH and both sides are ready.
- Reset mid-operation: all buffered flits are discarded immediately (asynchronous). On the first edge after rst returns high, ring_in_ready = 1.

Test Plan:
1. Reset, then ch0 push flits 0xA0..0xA2 (last on 0xA2) with out_ready=1, STORE_FWD=0 -> out_valid rises 1 cycle after the first push; output order A0, A1, A2, last only on A2; fill returns to 0.
2. DEPTH=8, out_ready=0, push 9 flits -> ring_in_ready drops after the 8th (fill=8); 9th held; raising out_ready drains in order; simultaneous push/pop keeps fill=7 steady.
3. STORE_FWD=1, push a 3-flit packet 1 cycle apart -> out_valid stays 0 until the cycle after the last flit, pkt_cnt=1, then 3 flits out and pkt_cnt=0.
4. STORE_FWD=1, 10-flit packet with DEPTH=8 -> at fill=8 and pkt_cnt=0 the escape opens and all 10 flits pass in order; the escape closes after the last pops; the next packet is held again.
5. Channel 0 stalled full while channel 1 streams 20 flits -> channel 1 unaffected, 1 flit/cycle; channel 0 data intact.
6. Assert rst low with fill=5 mid-packet -> fill=0, pkt_cnt=0, out_valid=0 immediately and in_ready=0; after release, a new packet passes cleanly with no stale flits.

Source files
------------

// File: rtl/riscv_debug_ring_link_buffer_if.sv
// Ring link bundle between two debug ring segments: one flit lane per channel
// with a valid/ready handshake and a last-of-packet marker.
interface riscv_debug_ring_link_buffer_if #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned CHANNELS = 2
);
   logic [CHANNELS-1:0][XLEN-1:0] data;
   logic [CHANNELS-1:0]           last;
   logic [CHANNELS-1:0]           valid;
   logic [CHANNELS-1:0]           ready;

   // Flit source side.
   modport master (output data, output last, output valid, input ready);
   // Flit sink side.
   modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/riscv_debug_ring_link_buffer.sv
// Per-channel elastic buffer between two debug ring segments. Each channel owns
// an independent FIFO with a registered input ready, so there is no
// combinational ready path across segments. With STORE_FWD set, a channel only
// presents flits once a complete packet is buffered. Packets larger than the
// FIFO open an escape that runs cut-through until that packet's last flit
// leaves.
module riscv_debug_ring_link_buffer #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned STORE_FWD = 0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   riscv_debug_ring_link_buffer_if.slave             ring_in,
   riscv_debug_ring_link_buffer_if.master            ring_out,
   output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]  fill,
   output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]  pkt_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [XLEN:0]   mem [DEPTH];
      logic [AW-1:0]   wr_ptr;
      logic [AW-1:0]   rd_ptr;
      logic [CW-1:0]   fill_q;
      logic [CW-1:0]   fill_d;
      logic [CW-1:0]   pkt_q;
      logic [CW-1:0]   pkt_d;
      logic            rdy_q;
      logic            open_q;
      logic            open_d;
      logic            full;
      logic            head_last;
      logic            out_valid;
      logic            push;
      logic            pop;
      logic            push_last;
      logic            pop_last;

      // Handshake decode and next-state for counters and the oversize escape.
      always_comb begin
         full      = (fill_q == FULL);
         head_last = mem[rd_ptr][XLEN];
         if (STORE_FWD != 0) begin
            out_valid = (fill_q != '0) & ((pkt_q != '0) | full | open_q);
         end else begin
            out_valid = (fill_q != '0);
         end
         push      = ring_in.valid[c] & rdy_q;
         pop       = out_valid & ring_out.ready[c];
         push_last = push & ring_in.last[c];
         pop_last  = pop & head_last;

         fill_d = fill_q;
         if (push && !pop) begin
            fill_d = fill_q + CW'(1);
         end else if (!push && pop) begin
            fill_d = fill_q - CW'(1);
         end

         pkt_d = pkt_q;
         if (push_last && !pop_last) begin
            pkt_d = pkt_q + CW'(1);
         end else if (!push_last && pop_last) begin
            pkt_d = pkt_q - CW'(1);
         end

         // A full FIFO with no complete packet can never release on its own,
         // so open the escape; it closes when the oversize packet's tail leaves.
         open_d = open_q;
         if (pop_last) begin
            open_d = 1'b0;
         end else if (full && (pkt_q == '0)) begin
            open_d = 1'b1;
         end
      end

      // Flit storage write; contents are intentionally left unreset.
      always_ff @(posedge clk) begin
         if (push) begin
            mem[wr_ptr] <= {ring_in.last[c], ring_in.data[c]};
         end
      end

      // Pointer, counter, ready and escape registers.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            pkt_q  <= '0;
            rdy_q  <= 1'b0;
            open_q <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            fill_q <= fill_d;
            pkt_q  <= pkt_d;
            rdy_q  <= (fill_d != FULL);
            open_q <= open_d;
         end
      end

      assign ring_in.ready[c]  = rdy_q;
      assign ring_out.valid[c] = out_valid;
      assign ring_out.data[c]  = mem[rd_ptr][XLEN-1:0];
      assign ring_out.last[c]  = head_last;
      assign fill[c]           = fill_q;
      assign pkt_cnt[c]        = pkt_q;
   end

endmodule

// File: tb/tb_riscv_debug_ring_link_buffer.sv
// Bench for riscv_debug_ring_link_buffer: one cut-through instance (index 0)
// and one store-and-forward instance (index 1), checked every cycle against
// queue-based per-channel models.
module tb_riscv_debug_ring_link_buffer;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CH    = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned W     = XLEN + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [CH-1:0]           in_valid  [2];
   logic [CH-1:0]           in_last   [2];
   logic [CH-1:0][XLEN-1:0] in_data   [2];
   logic [CH-1:0]           out_ready [2];
   logic [CH-1:0]           obs_valid [2];
   logic [CH-1:0]           obs_last  [2];
   logic [CH-1:0]           obs_ready [2];
   logic [CH-1:0][XLEN-1:0] obs_data  [2];
   logic [CH-1:0][CW-1:0]   fill_o    [2];
   logic [CH-1:0][CW-1:0]   pkt_o     [2];

   riscv_debug_ring_link_buffer_if #(.XLEN(XLEN), .CHANNELS(CH)) in_ct ();
   riscv_debug_ring_link_buffer_if #(.XLEN(XLEN), .CHANNELS(CH)) out_ct ();
   riscv_debug_ring_link_buffer_if #(.XLEN(XLEN), .CHANNELS(CH)) in_sf ();
   riscv_debug_ring_link_buffer_if #(.XLEN(XLEN), .CHANNELS(CH)) out_sf ();

   assign in_ct.valid  = in_valid[0];
   assign in_ct.last   = in_last[0];
   assign in_ct.data   = in_data[0];
   assign out_ct.ready = out_ready[0];
   assign in_sf.valid  = in_valid[1];
   assign in_sf.last   = in_last[1];
   assign in_sf.data   = in_data[1];
   assign out_sf.ready = out_ready[1];

   assign obs_valid[0] = out_ct.valid;
   assign obs_last[0]  = out_ct.last;
   assign obs_data[0]  = out_ct.data;
   assign obs_ready[0] = in_ct.ready;
   assign obs_valid[1] = out_sf.valid;
   assign obs_last[1]  = out_sf.last;
   assign obs_data[1]  = out_sf.data;
   assign obs_ready[1] = in_sf.ready;

   riscv_debug_ring_link_buffer #(
      .XLEN(XLEN), .CHANNELS(CH), .DEPTH(DEPTH), .STORE_FWD(0)
   ) dut_ct (
      .clk(clk), .rst(rst), .ring_in(in_ct.slave), .ring_out(out_ct.master),
      .fill(fill_o[0]), .pkt_cnt(pkt_o[0])
   );

   riscv_debug_ring_link_buffer #(
      .XLEN(XLEN), .CHANNELS(CH), .DEPTH(DEPTH), .STORE_FWD(1)
   ) dut_sf (
      .clk(clk), .rst(rst), .ring_in(in_sf.slave), .ring_out(out_sf.master),
      .fill(fill_o[1]), .pkt_cnt(pkt_o[1])
   );

   // Reference model: buffered {last, data} flits per instance and channel.
   logic [XLEN:0] q [2][CH][$];
   bit            open_m [2][CH];
   bit            armed;
   bit            acc [2][CH];
   int            tests  = 0;
   int            failed = 0;

   task automatic chk(string tag, logic [XLEN:0] obs, logic [XLEN:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int n_last(int d, int c);
      int n = 0;
      logic [XLEN:0] f;
      for (int i = 0; i < q[d][c].size(); i++) begin
         f = q[d][c][i];
         if (f[XLEN]) n++;
      end
      return n;
   endfunction

   function automatic bit exp_valid(int d, int c);
      int n = q[d][c].size();
      if (n == 0) return 1'b0;
      if (d == 0) return 1'b1;
      return (n_last(d, c) != 0) || (n == int'(DEPTH)) || open_m[d][c];
   endfunction

   function automatic bit exp_ready(int d, int c);
      return armed && (q[d][c].size() < int'(DEPTH));
   endfunction

   // Check every output at the falling edge, then advance the model at the rising edge.
   task automatic step();
      bit pu [2][CH];
      bit po [2][CH];
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < CH; c++) begin
            bit ev;
            bit er;
            logic [XLEN:0] h;
            ev = exp_valid(d, c);
            er = exp_ready(d, c);
            chk($sformatf("d%0d.c%0d valid", d, c), W'(obs_valid[d][c]), W'(ev));
            chk($sformatf("d%0d.c%0d in_ready", d, c), W'(obs_ready[d][c]), W'(er));
            chk($sformatf("d%0d.c%0d fill", d, c), W'(fill_o[d][c]), W'(q[d][c].size()));
            chk($sformatf("d%0d.c%0d pkt_cnt", d, c), W'(pkt_o[d][c]), W'(n_last(d, c)));
            if (ev) begin
               h = q[d][c][0];
               chk($sformatf("d%0d.c%0d data", d, c), W'(obs_data[d][c]), W'(h[XLEN-1:0]));
               chk($sformatf("d%0d.c%0d last", d, c), W'(obs_last[d][c]), W'(h[XLEN]));
            end
            pu[d][c] = in_valid[d][c] && er;
            po[d][c] = ev && out_ready[d][c];
         end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < CH; c++) begin
            logic [XLEN:0] h;
            bit stuck;
            stuck = (q[d][c].size() == int'(DEPTH)) && (n_last(d, c) == 0);
            if (po[d][c]) begin
               h = q[d][c].pop_front();
               if (h[XLEN]) open_m[d][c] = 1'b0;
               else if (stuck) open_m[d][c] = 1'b1;
            end else if (stuck) begin
               open_m[d][c] = 1'b1;
            end
            if (pu[d][c]) q[d][c].push_back({in_last[d][c], in_data[d][c]});
            acc[d][c] = pu[d][c];
         end
      end
      armed = (rst === 1'b1);
      #1;
   endtask

   task automatic send(int d, int c, logic [XLEN-1:0] data, logic last, int max_cyc,
                       output int cyc);
      in_valid[d][c] = 1'b1;
      in_data[d][c]  = data;
      in_last[d][c]  = last;
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!acc[d][c] && cyc < max_cyc);
      tests++;
      assert (acc[d][c]) else begin
         failed++;
         $error("FAIL send_timeout d%0d.c%0d: observed no accept after %0d cycles expected accept",
                d, c, cyc);
      end
   endtask

   task automatic idle(int n);
      for (int d = 0; d < 2; d++) in_valid[d] = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < CH; c++) begin
            q[d][c].delete();
            open_m[d][c] = 1'b0;
         end
      end
      armed = 1'b0;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < CH; c++) begin
            chk($sformatf("rst d%0d.c%0d valid", d, c), W'(obs_valid[d][c]), '0);
            chk($sformatf("rst d%0d.c%0d in_ready", d, c), W'(obs_ready[d][c]), '0);
            chk($sformatf("rst d%0d.c%0d fill", d, c), W'(fill_o[d][c]), '0);
            chk($sformatf("rst d%0d.c%0d pkt_cnt", d, c), W'(pkt_o[d][c]), '0);
         end
      end
      step();
      step();
      rst = 1'b1;
      step();
      step();
   endtask

   initial begin
      int cyc;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = '0;
         in_last[d]   = '0;
         in_data[d]   = '0;
         out_ready[d] = '0;
      end
      armed = 1'b0;
      #1;
      do_reset();

      // 1: cut-through 3-flit packet on ch0
      out_ready[0] = 2'b11;
      send(0, 0, 64'hA0, 1'b0, 20, cyc);
      send(0, 0, 64'hA1, 1'b0, 20, cyc);
      send(0, 0, 64'hA2, 1'b1, 20, cyc);
      idle(5);
      chk("t1 fill_empty", W'(fill_o[0][0]), '0);

      // 2: fill to DEPTH, hold the 9th, then drain while streaming
      out_ready[0] = 2'b00;
      for (int i = 0; i < 8; i++) send(0, 0, XLEN'(8'hB0 + i), 1'b0, 20, cyc);
      chk("t2 fill_full", W'(fill_o[0][0]), W'(DEPTH));
      in_valid[0][0] = 1'b1;
      in_data[0][0]  = 64'hB8;
      in_last[0][0]  = 1'b1;
      step();
      step();
      chk("t2 ninth_held", W'(obs_ready[0][0]), '0);
      out_ready[0] = 2'b11;
      send(0, 0, 64'hB8, 1'b1, 20, cyc);
      for (int i = 0; i < 4; i++) begin
         send(0, 0, XLEN'(8'hC0 + i), i == 3, 20, cyc);
         chk("t2 fill_steady", W'(fill_o[0][0]), W'(DEPTH - 1));
      end
      idle(10);

      // 3: store-and-forward holds until the last flit is in
      out_ready[1] = 2'b11;
      send(1, 0, 64'hD0, 1'b0, 20, cyc);
      send(1, 0, 64'hD1, 1'b0, 20, cyc);
      send(1, 0, 64'hD2, 1'b1, 20, cyc);
      chk("t3 pkt_cnt_one", W'(pkt_o[1][0]), W'(1));
      idle(5);
      chk("t3 pkt_cnt_zero", W'(pkt_o[1][0]), '0);

      // 4: oversize packet opens the escape; next packet is held again
      for (int i = 0; i < 10; i++) send(1, 0, XLEN'(12'hE00 + i), i == 9, 40, cyc);
      send(1, 0, 64'hF0, 1'b0, 20, cyc);
      send(1, 0, 64'hF1, 1'b0, 20, cyc);
      idle(12);
      chk("t4 next_held", W'(obs_valid[1][0]), '0);
      chk("t4 next_fill", W'(fill_o[1][0]), W'(2));
      send(1, 0, 64'hF2, 1'b1, 20, cyc);
      idle(6);

      // 5: ch0 stalled full, ch1 streams at full rate
      out_ready[0] = 2'b10;
      for (int i = 0; i < 8; i++) send(0, 0, {$urandom(), $urandom()}, i == 7, 20, cyc);
      for (int i = 0; i < 20; i++) begin
         send(0, 1, {$urandom(), $urandom()}, (i % 5) == 4, 20, cyc);
         chk("t5 ch1_rate", W'(cyc), W'(1));
      end
      in_valid[0] = '0;
      chk("t5 ch0_full", W'(fill_o[0][0]), W'(DEPTH));
      out_ready[0] = 2'b11;
      idle(10);

      // 6: reset mid-packet discards everything
      out_ready[0] = 2'b00;
      for (int i = 0; i < 5; i++) send(0, 0, XLEN'(8'h50 + i), 1'b0, 20, cyc);
      in_valid[0] = '0;
      chk("t6 fill_five", W'(fill_o[0][0]), W'(5));
      do_reset();
      out_ready[0] = 2'b11;
      send(0, 0, 64'h60, 1'b0, 20, cyc);
      send(0, 0, 64'h61, 1'b1, 20, cyc);
      idle(5);

      // Random soak on both instances; held flits stay stable until accepted.
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
               if (!in_valid[d][c] || acc[d][c]) begin
                  in_valid[d][c] = ($urandom_range(0, 3) != 0);
                  in_data[d][c]  = {$urandom(), $urandom()};
                  in_last[d][c]  = ($urandom_range(0, 3) == 0);
               end
               out_ready[d][c] = ($urandom_range(0, 2) != 0);
            end
         end
         step();
      end
      for (int d = 0; d < 2; d++) out_ready[d] = 2'b11;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
